// File: rtl/bcd_entry_encoder.sv
// Debounced 4-digit BCD entry with iterative reverse double-dabble commit.
// Optional KEY1 auto-repeat is enabled by defining BCD_ENTRY_AUTOREPEAT_EN.
module bcd_entry_encoder #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_VALUE       = 9999,
    parameter int REPEAT_CYCLES   = 12_500_000
) (
    input  logic        clk_50MHz,
    input  logic        KEY0,
    input  logic        KEY1,
    input  logic        KEY2,
    input  logic        KEY3,
    output logic [3:0]  bcd3,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd0,
    output logic [1:0]  digit_sel,
    output logic        busy,
    output logic        value_valid,
    output logic [13:0] value,
    output logic        range_err
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [13:0] MAXV = 14'(MAX_VALUE);

    logic [2:0]    keys;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    level;
    logic [2:0]    press;
    logic [CW-1:0] cnt [3];

    assign keys = {KEY3, KEY2, KEY1};

    // level is the accepted key state (1 = released); press fires on accepted fall
    always_ff @(posedge clk_50MHz) begin
        if (!KEY0) begin
            s1    <= '1;
            s2    <= '1;
            level <= '1;
            press <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1 <= keys;
            s2 <= s1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    cnt[i]   <= '0;
                    level[i] <= s2[i];
                    press[i] <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    state_t          state;
    logic [3:0][3:0] dig;
    logic [15:0]     bcd_sr;
    logic [13:0]     bin_acc;
    logic [3:0]      iter;
    logic            inc_evt;

`ifdef BCD_ENTRY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_evt;

    // Period counts from the initial press pulse, so the count starts at 1
    always_ff @(posedge clk_50MHz) begin
        if (!KEY0) begin
            rep_cnt <= '0;
            rep_evt <= 1'b0;
        end else if (press[0]) begin
            rep_cnt <= RW'(1);
            rep_evt <= 1'b0;
        end else if (level[0] || busy) begin
            rep_cnt <= '0;
            rep_evt <= 1'b0;
        end else if (rep_cnt == RLAST) begin
            rep_cnt <= '0;
            rep_evt <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
            rep_evt <= 1'b0;
        end
    end

    assign inc_evt = press[0] | rep_evt;
`else
    assign inc_evt = press[0];
`endif

    logic [29:0] shifted;
    logic [15:0] nxt_sr;

    always_comb begin
        shifted = {bcd_sr, bin_acc} >> 1;
        nxt_sr  = shifted[29:14];
        for (int i = 0; i < 4; i++) begin
            if (nxt_sr[4*i +: 4] >= 4'd8) begin
                nxt_sr[4*i +: 4] = nxt_sr[4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!KEY0) begin
            state       <= IDLE;
            dig         <= '0;
            digit_sel   <= '0;
            bcd_sr      <= '0;
            bin_acc     <= '0;
            iter        <= '0;
            busy        <= 1'b0;
            value_valid <= 1'b0;
            value       <= '0;
            range_err   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            range_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (press[2]) begin
                        bcd_sr  <= dig;
                        bin_acc <= '0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end else begin
                        if (inc_evt) begin
                            dig[digit_sel] <= (dig[digit_sel] == 4'd9) ?
                                4'd0 : dig[digit_sel] + 4'd1;
                        end
                        if (press[1]) digit_sel <= digit_sel + 2'd1;
                    end
                end
                CONVERT: begin
                    bcd_sr  <= nxt_sr;
                    bin_acc <= shifted[13:0];
                    iter    <= iter + 4'd1;
                    if (iter == 4'd13) state <= DONE;
                end
                DONE: begin
                    value       <= (bin_acc > MAXV) ? MAXV : bin_acc;
                    range_err   <= (bin_acc > MAXV);
                    value_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bcd3 = dig[3];
    assign bcd2 = dig[2];
    assign bcd1 = dig[1];
    assign bcd0 = dig[0];

endmodule

// File: tb/tb_bcd_entry_encoder.sv
// Directed bench for bcd_entry_encoder; a second instance with
// MAX_VALUE = 5000 shares the stimulus to exercise saturation.
module tb_bcd_entry_encoder;

    logic        clk = 1'b0;
    logic        KEY0 = 1'b0;
    logic        KEY1 = 1'b1;
    logic        KEY2 = 1'b1;
    logic        KEY3 = 1'b1;

    logic [3:0]  bcd3, bcd2, bcd1, bcd0;
    logic [1:0]  digit_sel;
    logic        busy, value_valid, range_err;
    logic [13:0] value;

    logic [3:0]  s_bcd3, s_bcd2, s_bcd1, s_bcd0;
    logic [1:0]  s_digit_sel;
    logic        s_busy, s_value_valid, s_range_err;
    logic [13:0] s_value;

    int n_checks = 0;
    int n_fail   = 0;

    int          w_busy, w_first, w_valid, w_vk, w_err, w_stray;
    logic [13:0] w_val;
    int          s_valid, s_err;
    logic [13:0] s_val;
    logic [34:0] r_snap;

    always #10 clk = ~clk;

    bcd_entry_encoder #(
        .DEBOUNCE_CYCLES(4),
        .MAX_VALUE(9999),
        .REPEAT_CYCLES(1000)
    ) dut (
        .clk_50MHz(clk), .KEY0(KEY0), .KEY1(KEY1), .KEY2(KEY2), .KEY3(KEY3),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .digit_sel(digit_sel), .busy(busy), .value_valid(value_valid),
        .value(value), .range_err(range_err)
    );

    bcd_entry_encoder #(
        .DEBOUNCE_CYCLES(4),
        .MAX_VALUE(5000),
        .REPEAT_CYCLES(1000)
    ) dut_sat (
        .clk_50MHz(clk), .KEY0(KEY0), .KEY1(KEY1), .KEY2(KEY2), .KEY3(KEY3),
        .bcd3(s_bcd3), .bcd2(s_bcd2), .bcd1(s_bcd1), .bcd0(s_bcd0),
        .digit_sel(s_digit_sel), .busy(s_busy), .value_valid(s_value_valid),
        .value(s_value), .range_err(s_range_err)
    );

    task automatic drive_key(input int k, input logic v);
        case (k)
            1: KEY1 = v;
            2: KEY2 = v;
            default: KEY3 = v;
        endcase
    endtask

    task automatic tap(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            drive_key(k, 1'b0);
            repeat (8) @(negedge clk);
            drive_key(k, 1'b1);
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        KEY0 = 1'b0;
        repeat (2) @(negedge clk);
        KEY0 = 1'b1;
        @(negedge clk);
    endtask

    // Drives a commit (KEY3 fall in cycle 0) and records what both instances do
    task automatic commit_watch(input int kmax, input bit with_inc,
                                input bit sel_mid, input int rst_at);
        w_busy = 0; w_first = -1; w_valid = 0; w_vk = -1;
        w_err = 0; w_stray = 0; w_val = '0;
        s_valid = 0; s_err = 0; s_val = '0; r_snap = '1;
        KEY3 = 1'b0;
        if (with_inc) KEY1 = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            if (busy) begin
                w_busy++;
                if (w_first < 0) w_first = k;
            end
            if (value_valid) begin
                w_valid++; w_vk = k; w_val = value; w_err = range_err;
            end
            if (range_err && !value_valid) w_stray++;
            if (s_value_valid) begin
                s_valid++; s_val = s_value; s_err += s_range_err;
            end
            if (k == rst_at + 1)
                r_snap = {bcd3, bcd2, bcd1, bcd0, digit_sel, busy,
                          value_valid, value, range_err};
            if (k == 8) begin
                KEY3 = 1'b1;
                KEY1 = 1'b1;
                if (sel_mid) KEY2 = 1'b0;
            end
            if (k == 16 && sel_mid) KEY2 = 1'b1;
            if (k == rst_at) KEY0 = 1'b0;
            if (k == rst_at + 2) KEY0 = 1'b1;
        end
    endtask

    task automatic test_reset();
        KEY0 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bcd3, bcd2, bcd1, bcd0} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_digits: got %h want 0000", {bcd3, bcd2, bcd1, bcd0});
        end
        n_checks++;
        if ({digit_sel, busy, value_valid, range_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {digit_sel, busy, value_valid, range_err});
        end
        n_checks++;
        if (value !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_value: got %0d want 0", value);
        end
        KEY0 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_debounce();
        KEY1 = 1'b0;
        repeat (3) @(negedge clk);
        KEY1 = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (bcd0 !== 4'd0) begin
            n_fail++;
            $display("FAIL glitch_rejected: got bcd0=%0d want 0", bcd0);
        end
        KEY1 = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (bcd0 !== 4'd0) begin
            n_fail++;
            $display("FAIL event_not_early: got bcd0=%0d want 0 in cycle 6", bcd0);
        end
        @(negedge clk);
        n_checks++;
        if (bcd0 !== 4'd1) begin
            n_fail++;
            $display("FAIL event_latency: got bcd0=%0d want 1 in cycle 7", bcd0);
        end
        repeat (3) @(negedge clk);
        KEY1 = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (bcd0 !== 4'd1) begin
            n_fail++;
            $display("FAIL one_per_press: got bcd0=%0d want 1", bcd0);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        tap(1, 9);
        n_checks++;
        if (bcd0 !== 4'd9) begin
            n_fail++;
            $display("FAIL inc_to_9: got %0d want 9", bcd0);
        end
        tap(1, 1);
        n_checks++;
        if (bcd0 !== 4'd0) begin
            n_fail++;
            $display("FAIL digit_wrap: got %0d want 0", bcd0);
        end
        tap(2, 1);
        n_checks++;
        if (digit_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL sel_advance: got %0d want 1", digit_sel);
        end
        tap(2, 3);
        n_checks++;
        if (digit_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL sel_wrap: got %0d want 0", digit_sel);
        end
    endtask

    task automatic test_convert();
        tap(1, 6); tap(2, 1);
        tap(1, 7); tap(2, 1);
        tap(1, 8); tap(2, 1);
        tap(1, 9);
        n_checks++;
        if ({bcd3, bcd2, bcd1, bcd0, digit_sel} !== {16'h9876, 2'd3}) begin
            n_fail++;
            $display("FAIL entry_9876: got %h sel %0d want 9876 sel 3",
                     {bcd3, bcd2, bcd1, bcd0}, digit_sel);
        end
        commit_watch(30, 1'b0, 1'b0, -10);
        n_checks++;
        if (w_first !== 7 || w_busy !== 15) begin
            n_fail++;
            $display("FAIL busy_window: got first %0d len %0d want 7 15", w_first, w_busy);
        end
        n_checks++;
        if (w_valid !== 1 || w_vk !== 22) begin
            n_fail++;
            $display("FAIL valid_pulse: got count %0d cycle %0d want 1 22", w_valid, w_vk);
        end
        n_checks++;
        if (w_val !== 14'd9876 || w_err !== 0) begin
            n_fail++;
            $display("FAIL convert_value: got %0d err %0d want 9876 0", w_val, w_err);
        end
        n_checks++;
        if (w_stray !== 0) begin
            n_fail++;
            $display("FAIL range_err_stray: got %0d want 0", w_stray);
        end
        n_checks++;
        if (s_val !== 14'd5000 || s_err !== 1) begin
            n_fail++;
            $display("FAIL sat_9876: got %0d err %0d want 5000 1", s_val, s_err);
        end
        n_checks++;
        if (value !== 14'd9876 || {bcd3, bcd2, bcd1, bcd0} !== 16'h9876) begin
            n_fail++;
            $display("FAIL value_hold: got %0d digits %h want 9876", value,
                     {bcd3, bcd2, bcd1, bcd0});
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        tap(1, 1); tap(2, 3); tap(1, 7);
        n_checks++;
        if ({bcd3, bcd2, bcd1, bcd0} !== 16'h7001) begin
            n_fail++;
            $display("FAIL entry_7001: got %h want 7001", {bcd3, bcd2, bcd1, bcd0});
        end
        commit_watch(30, 1'b0, 1'b0, -10);
        n_checks++;
        if (s_valid !== 1 || s_val !== 14'd5000 || s_err !== 1) begin
            n_fail++;
            $display("FAIL saturate: got valid %0d val %0d err %0d want 1 5000 1",
                     s_valid, s_val, s_err);
        end
        n_checks++;
        if (w_val !== 14'd7001 || w_err !== 0) begin
            n_fail++;
            $display("FAIL no_saturate: got %0d err %0d want 7001 0", w_val, w_err);
        end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        tap(1, 5);
        commit_watch(40, 1'b1, 1'b1, -10);
        n_checks++;
        if (w_valid !== 1 || w_val !== 14'd5) begin
            n_fail++;
            $display("FAIL simul_value: got count %0d val %0d want 1 5", w_valid, w_val);
        end
        n_checks++;
        if (bcd0 !== 4'd5) begin
            n_fail++;
            $display("FAIL simul_inc_dropped: got bcd0=%0d want 5", bcd0);
        end
        n_checks++;
        if (digit_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL sel_frozen_busy: got %0d want 0", digit_sel);
        end
    endtask

    task automatic test_reset_mid();
        commit_watch(45, 1'b0, 1'b0, 14);
        n_checks++;
        if (r_snap !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h want 0", r_snap);
        end
        n_checks++;
        if (w_valid !== 0 || value !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got valid %0d value %0d want 0 0",
                     w_valid, value);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_convert();
        test_saturation();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_entry_encoder.md
# bcd_entry_encoder

User-input front end for the 7-segment counter design. It takes raw pushbuttons, debounces them, and lets the user dial in a 4-digit BCD value one digit at a time. On commit it converts the digits to a 14-bit binary value with an iterative reverse double-dabble (BCD to binary), then presents that value with a one-cycle valid pulse. It is the input direction of the binary-to-BCD display path: the entered digits drive the HEX decoders, and the binary result loads the counter.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: stable-level cycles required to accept a press or release (20 ms at 50 MHz).
- MAX_VALUE, 9999: saturation limit for the converted result (14-bit).
- REPEAT_CYCLES, 12_500_000: auto-repeat period. Used only with BCD_ENTRY_AUTOREPEAT_EN.

Ports:
- clk_50MHz  in  1  sole clock.
- KEY0  in  1  reset, synchronous, active-low.
- KEY1  in  1  raw button, active-low: increment the selected digit.
- KEY2  in  1  raw button, active-low: advance the digit select.
- KEY3  in  1  raw button, active-low: commit and convert.
- bcd3, bcd2, bcd1, bcd0  out  4 each  entered digits (thousands to ones).
- digit_sel  out  2  currently selected digit (0 = ones).
- busy  out  1  high while converting.
- value_valid  out  1  one-cycle pulse when value is updated.
- value  out  14  converted binary value; holds between commits.
- range_err  out  1  pulses with value_valid when saturation occurred.

## Operation
- Reset (KEY0 = 0 at a clock edge):
  - All digits 0, digit_sel 0, busy 0, value_valid 0, value 0, range_err 0, FSM IDLE.
  - Synchronizer and debounce state cleared to "released".
- Each of KEY1..KEY3 passes through a 2-flop synchronizer and a debouncer:
  - The debouncer accepts a new level after DEBOUNCE_CYCLES consecutive equal samples.
  - A press event is a one-cycle pulse on the accepted high-to-low transition.
  - Exactly one pulse per press. The key must be accepted released before the next press counts.
- FSM states:
  - IDLE:
    - KEY1 event: bcd[digit_sel] increments, 9 wraps to 0.
    - KEY2 event: digit_sel increments, 3 wraps to 0.
    - KEY3 event: snapshot digits into a 16-bit shift register, clear the binary accumulator, go to CONVERT.
  - CONVERT (14 cycles, iteration counter 0..13):
    - Shift {bcd_sr, bin_acc} right by one.
    - Then subtract 3 from each BCD nibble that is ≥ 8.
    - After the 14th iteration, go to DONE.
  - DONE (1 cycle):
    - value = min(bin_acc, MAX_VALUE).
    - range_err = (bin_acc > MAX_VALUE).
    - Pulse value_valid, return to IDLE.
- Simultaneous events in IDLE:
  - KEY1 and KEY2 in the same cycle: the increment applies to the old digit_sel, and digit_sel also advances.
  - KEY3 with KEY1 or KEY2: the commit snapshots the pre-increment digits, and the KEY1/KEY2 events are discarded.
- Events arriving during CONVERT or DONE are dropped, not queued. Digits and digit_sel are frozen while busy.
- Reset mid-conversion aborts: no value_valid, and value returns to 0.

## Timing
- Raw key fall to event pulse: 2 + DEBOUNCE_CYCLES cycles for a clean edge.
- Digit and digit_sel updates appear the cycle after the event pulse.
- Commit latency:
  - KEY3 event at cycle N: busy = 1 in cycles N+1..N+15.
  - value, range_err and value_valid update at the edge ending cycle N+15 and are visible in cycle N+16.
  - busy returns to 0 in cycle N+16.
- value_valid and range_err are high for exactly one cycle per commit. range_err is 0 whenever value_valid is 0.
- Back-to-back commits are accepted only after busy has deasserted.

## Configuration
- BCD_ENTRY_AUTOREPEAT_EN defined:
  - While KEY1 stays accepted-pressed, an additional increment event fires every REPEAT_CYCLES, counted from the initial press pulse.
  - Repeat stops on accepted release, and is suppressed while busy.
- Undefined: exactly one increment per press. REPEAT_CYCLES is unused and its logic is absent.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Debounce: KEY1 glitches low for 3 cycles, then a clean 10-cycle press -> exactly one increment, so bcd0 goes 0 -> 1. The event pulse occurs 6 cycles after the clean fall.
- Wrap: 10 KEY1 presses on digit 0 -> bcd0 = 0. 4 KEY2 presses -> digit_sel = 0.
- Convert: enter digits 9,8,7,6 (bcd3..bcd0), then press KEY3 -> busy for 15 cycles, then value = 9876 (0x2694) with a one-cycle value_valid and range_err = 0.
- Saturation: MAX_VALUE = 5000, enter 7,0,0,1 and commit -> value = 5000, range_err pulses with value_valid.
- Simultaneous and busy: KEY1 and KEY3 events in the same cycle at digits 0,0,0,5 -> value = 5 and bcd0 stays 5. A KEY2 press during busy leaves digit_sel unchanged.
- Reset mid-operation: KEY0 low at conversion cycle 7 -> no value_valid, and all outputs are 0 the cycle after.
